// File: rtl/wb_burst_mem_slave.sv
// Wishbone B3 slave backed by a 2^AW x 32 word memory.
// Serves classic cycles and linear incrementing bursts with
// programmable initial wait states, flags unsupported cycle
// types with wb_err_o, and counts acked beats and completed bursts.
// Ports: clk, rst (async, high); wb_* slave bus; beat_cnt_o,
// burst_cnt_o status counters (wrap modulo 2^16).
module wb_burst_mem_slave #(
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [15:0] beat_cnt_o,
  output logic [15:0] burst_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    BURST,
    CLASSIC_GAP,
    ERR
  } state_t;

  localparam logic [2:0]    CTI_CLASSIC = 3'b000;
  localparam logic [2:0]    CTI_INCR    = 3'b010;
  localparam logic [2:0]    CTI_END     = 3'b111;
  localparam logic [3:0]    WAIT_INIT   = 4'(WAIT_CYCLES);
  localparam logic [AW-1:0] ONE         = 1;

  logic [31:0]   mem [2**AW];

  state_t        state;
  logic [AW-1:0] cur_adr;
  logic [3:0]    wcnt;
  logic          ack_q;
  logic          err_q;
  logic          is_burst;
  logic [31:0]   dat_q;
  logic [15:0]   beat_cnt;
  logic [15:0]   burst_cnt;

  logic [AW-1:0] req_adr;
  logic [AW-1:0] nxt_adr;
  logic          req;
  logic          xfer;
  logic          bad_cti;
  logic          bad_req;
  logic          unused_adr;

  assign req_adr    = wb_adr_i[AW+1:2];
  assign nxt_adr    = cur_adr + ONE;
  assign req        = wb_cyc_i & wb_stb_i;
  assign unused_adr = ^wb_adr_i[31:AW+2];

  // Outputs are gated by the live strobe so a master that drops
  // stb/cyc never sees a stale termination.
  assign wb_ack_o = ack_q & req;
  assign wb_err_o = err_q & req;
  assign xfer     = wb_ack_o;

  assign wb_dat_o    = dat_q;
  assign beat_cnt_o  = beat_cnt;
  assign burst_cnt_o = burst_cnt;

  assign bad_cti = (wb_cti_i != CTI_CLASSIC) &&
                   (wb_cti_i != CTI_INCR) &&
                   (wb_cti_i != CTI_END);

  assign bad_req = (wb_adr_i[1:0] != 2'b00) || bad_cti ||
                   ((wb_cti_i == CTI_INCR) && (wb_bte_i != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_adr   <= '0;
      wcnt      <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      is_burst  <= 1'b0;
      dat_q     <= '0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            cur_adr  <= req_adr;
            wcnt     <= WAIT_INIT;
            is_burst <= (wb_cti_i == CTI_INCR);
            if (bad_req) begin
              err_q <= 1'b1;
              state <= ERR;
            end else if (WAIT_CYCLES > 0) begin
              state <= WAIT;
            end else begin
              ack_q <= 1'b1;
              dat_q <= mem[req_adr];
              state <= BURST;
            end
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (wcnt <= 4'd1) begin
            ack_q <= 1'b1;
            dat_q <= mem[cur_adr];
            state <= BURST;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        // Ack phase for both classic and burst cycles.
        BURST: begin
          if (!wb_cyc_i) begin
            ack_q <= 1'b0;
            state <= IDLE;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (!is_burst) begin
              ack_q <= 1'b0;
              state <= CLASSIC_GAP;
            end else if (wb_cti_i == CTI_END) begin
              burst_cnt <= burst_cnt + 16'd1;
              ack_q     <= 1'b0;
              state     <= CLASSIC_GAP;
            end else begin
              // Prefetch the next word so it is ready next cycle.
              cur_adr <= nxt_adr;
              dat_q   <= mem[nxt_adr];
            end
          end
        end
        ERR: begin
          err_q <= 1'b0;
          state <= CLASSIC_GAP;
        end
        CLASSIC_GAP: begin
          state <= IDLE;
        end
        default: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (xfer && wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          mem[cur_adr][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Directed bench for wb_burst_mem_slave: one instance with no
// wait states and one with two, sharing the bus except cyc.
module tb_wb_burst_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  int          dsel = 0;

  logic        cyc0, cyc2;
  logic [31:0] dat0, dat2;
  logic        ack0, ack2, err0, err2;
  logic [15:0] beat0, beat2, bst0, bst2;

  logic        ack_m, err_m;
  logic [31:0] dat_m;
  logic [15:0] beat_m, bst_m;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] rbuf [16];

  always #5 clk = ~clk;

  assign cyc0   = cyc & (dsel == 0);
  assign cyc2   = cyc & (dsel == 2);
  assign ack_m  = (dsel == 2) ? ack2 : ack0;
  assign err_m  = (dsel == 2) ? err2 : err0;
  assign dat_m  = (dsel == 2) ? dat2 : dat0;
  assign beat_m = (dsel == 2) ? beat2 : beat0;
  assign bst_m  = (dsel == 2) ? bst2 : bst0;

  wb_burst_mem_slave #(.AW(8), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat0),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb),
    .wb_cyc_i(cyc0), .wb_ack_o(ack0), .wb_err_o(err0),
    .wb_cti_i(cti), .wb_bte_i(bte),
    .beat_cnt_o(beat0), .burst_cnt_o(bst0)
  );

  wb_burst_mem_slave #(.AW(8), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat2),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb),
    .wb_cyc_i(cyc2), .wb_ack_o(ack2), .wb_err_o(err2),
    .wb_cti_i(cti), .wb_bte_i(bte),
    .beat_cnt_o(beat2), .burst_cnt_o(bst2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic classic(input logic [31:0] a, input bit w,
                         input logic [31:0] wd, input logic [3:0] s,
                         output logic [31:0] rd, output int lat);
    bit got;
    repeat (2) @(posedge clk);
    #1;
    adr = a; we = w; wdat = wd; sel = s;
    cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    lat = 0; got = 0; rd = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (ack_m) begin
        got = 1;
        rd = dat_m;
      end
      @(posedge clk);
      #1;
      if (!got) lat++;
    end
    if (!got) chk("classic_timeout", 32'(lat), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic burst(input logic [31:0] a, input int n,
                       input int stall_at, input int stall_len,
                       input int abort_at,
                       output int first_lat, output int cycles);
    int  b, stall;
    bit  done, acked;
    repeat (2) @(posedge clk);
    #1;
    adr = a; we = 1'b0; sel = 4'hF; bte = 2'b00;
    cti = (n == 1) ? 3'b111 : 3'b010;
    cyc = 1'b1; stb = 1'b1;
    b = 0; cycles = 0; first_lat = -1; stall = 0; done = 0;
    while (!done && cycles < 100) begin
      @(negedge clk);
      acked = ack_m;
      if (!stb) chk("stall_noack", 32'(ack_m), 32'd0);
      if (acked) begin
        if (first_lat < 0) first_lat = cycles;
        rbuf[b] = dat_m;
      end
      @(posedge clk);
      cycles++;
      #1;
      if (acked) begin
        b++;
        if (b == n || b == abort_at) begin
          done = 1;
        end else begin
          cti = (b == n - 1) ? 3'b111 : 3'b010;
          if (b == stall_at + 1 && stall_len > 0) begin
            stb = 1'b0;
            stall = stall_len;
          end
        end
      end else if (stall > 0) begin
        stall--;
        if (stall == 0) stb = 1'b1;
      end
    end
    if (!done) chk("burst_timeout", 32'(b), 32'(n));
    if (done && b == n) begin
      @(negedge clk);
      chk("ack_after_last", 32'(ack_m), 32'd0);
      @(posedge clk);
      #1;
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
  endtask

  task automatic err_req(input logic [31:0] a, input logic [2:0] c,
                         input logic [1:0] bt);
    repeat (2) @(posedge clk);
    #1;
    adr = a; we = 1'b1; wdat = 32'h5A5A5A5A; sel = 4'hF;
    cti = c; bte = bt; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    chk("err_before", 32'(err_m), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("err_n1", 32'(err_m), 32'd1);
    chk("err_no_ack", 32'(ack_m), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("err_one_cycle", 32'(err_m), 32'd0);
    chk("err_no_ack2", 32'(ack_m), 32'd0);
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  logic [31:0] rd;
  int          lat, fl, cy;

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_dat0", dat0, 32'd0);
    chk("rst_beat0", 32'(beat0), 32'd0);
    chk("rst_burst0", 32'(bst0), 32'd0);
    chk("rst_dat2", dat2, 32'd0);
    chk("rst_beat2", 32'(beat2), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Classic write/read, no wait states
    dsel = 0;
    classic(32'h10, 1, 32'hDEADBEEF, 4'hF, rd, lat);
    chk("cl_wr_lat", 32'(lat), 32'd1);
    classic(32'h10, 0, 32'h0, 4'hF, rd, lat);
    chk("cl_rd_lat", 32'(lat), 32'd1);
    chk("cl_rd_dat", rd, 32'hDEADBEEF);
    chk("cl_beat", 32'(beat_m), 32'd2);
    chk("cl_burst", 32'(bst_m), 32'd0);

    // Fill pattern through the 2-wait-state slave
    dsel = 2;
    for (int i = 0; i < 8; i++) begin
      classic(32'(4 * i), 1, 32'h01020304 + 32'h04040404 * i, 4'hF,
              rd, lat);
      chk("fill_lat", 32'(lat), 32'd3);
    end

    // 8-beat burst read
    burst(32'h0, 8, -1, 0, 0, fl, cy);
    chk("b8_first_lat", 32'(fl), 32'd3);
    chk("b8_cycles", 32'(cy), 32'd11);
    for (int i = 0; i < 8; i++)
      chk("b8_dat", rbuf[i], 32'h01020304 + 32'h04040404 * i);
    chk("b8_beat", 32'(beat_m), 32'd16);
    chk("b8_burst", 32'(bst_m), 32'd1);

    // Burst with stb dropped for 2 cycles after beat 3
    burst(32'h0, 8, 3, 2, 0, fl, cy);
    chk("st_cycles", 32'(cy), 32'd13);
    chk("st_dat4", rbuf[4], 32'h11121314);
    chk("st_dat7", rbuf[7], 32'h1D1E1F20);
    chk("st_beat", 32'(beat_m), 32'd24);
    chk("st_burst", 32'(bst_m), 32'd2);

    // Address wrap 255 -> 0
    dsel = 0;
    classic(32'h3F8, 1, 32'hCAFE00FE, 4'hF, rd, lat);
    classic(32'h3FC, 1, 32'hCAFE00FF, 4'hF, rd, lat);
    classic(32'h000, 1, 32'hCAFE0000, 4'hF, rd, lat);
    classic(32'h004, 1, 32'hCAFE0001, 4'hF, rd, lat);
    burst(32'h3F8, 4, -1, 0, 0, fl, cy);
    chk("wr_first_lat", 32'(fl), 32'd1);
    chk("wr_cycles", 32'(cy), 32'd5);
    chk("wr_dat0", rbuf[0], 32'hCAFE00FE);
    chk("wr_dat1", rbuf[1], 32'hCAFE00FF);
    chk("wr_dat2", rbuf[2], 32'hCAFE0000);
    chk("wr_dat3", rbuf[3], 32'hCAFE0001);
    chk("wr_beat", 32'(beat_m), 32'd10);
    chk("wr_burst", 32'(bst_m), 32'd1);

    // Byte lanes
    classic(32'h20, 1, 32'h11223344, 4'hF, rd, lat);
    classic(32'h20, 1, 32'h00AB0000, 4'b0100, rd, lat);
    classic(32'h20, 0, 32'h0, 4'hF, rd, lat);
    chk("sel_dat", rd, 32'h11AB3344);
    classic(32'h20, 1, 32'hFFFFFFFF, 4'b0000, rd, lat);
    chk("sel0_lat", 32'(lat), 32'd1);
    classic(32'h20, 0, 32'h0, 4'hF, rd, lat);
    chk("sel0_dat", rd, 32'h11AB3344);
    chk("sel_beat", 32'(beat_m), 32'd15);

    // Error terminations
    err_req(32'h22, 3'b000, 2'b00);
    err_req(32'h0, 3'b001, 2'b00);
    chk("err_beat0", 32'(beat_m), 32'd15);
    chk("err_burst0", 32'(bst_m), 32'd1);
    classic(32'h0, 0, 32'h0, 4'hF, rd, lat);
    chk("err_word0", rd, 32'hCAFE0000);
    dsel = 2;
    err_req(32'h0, 3'b010, 2'b01);
    chk("err_beat2", 32'(beat_m), 32'd24);
    chk("err_burst2", 32'(bst_m), 32'd2);

    // cyc dropped after 3 beats
    burst(32'h0, 8, -1, 0, 3, fl, cy);
    chk("ab_dat2", rbuf[2], 32'h090A0B0C);
    chk("ab_beat", 32'(beat_m), 32'd27);
    chk("ab_burst", 32'(bst_m), 32'd2);
    classic(32'h8, 0, 32'h0, 4'hF, rd, lat);
    chk("ab_cl_lat", 32'(lat), 32'd3);
    chk("ab_cl_dat", rd, 32'h090A0B0C);
    chk("ab_cl_beat", 32'(beat_m), 32'd28);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_burst_mem_slave.md
# wb_burst_mem_slave

Synthesizable Wishbone B3 slave with an internal word memory that serves as the far end of the display controller's Wishbone master port. It answers classic single transfers and linear incrementing bursts (cti 010) with programmable initial wait states, so framebuffer fetch behaviour can be exercised on the bench and in FPGA bring-up without the external SRAM controller. Bus errors flag unsupported cycle types. Status counters expose completed beats and bursts.

## Interface
- AW, 8: memory depth is 2^AW 32-bit words, indexed by wb_adr_i[AW+1:2].
- WAIT_CYCLES, 0: wait states inserted before the first ack of every classic transfer or burst (0..15).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_adr_i  in  32  byte address, sampled at cycle start only.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid when wb_ack_o=1.
- wb_sel_i  in  4  byte enables; bit 3 = bits 31:24.
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle valid.
- wb_ack_o  out  1  transfer acknowledge.
- wb_err_o  out  1  error termination.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end of burst.
- wb_bte_i  in  2  burst type; only 00 (linear) is supported.
- beat_cnt_o  out  16  count of acked beats, wraps modulo 2^16.
- burst_cnt_o  out  16  count of bursts completed by an acked cti=111 beat, wraps.

## Operation
- States: IDLE, WAIT, BURST, CLASSIC_GAP, ERR.
- IDLE: on cyc&stb, latch cur_adr <= wb_adr_i[AW+1:2], load wait counter with WAIT_CYCLES.
  - wb_adr_i[1:0]!=0, cti in {001,011..110}, or cti=010 with bte!=00 -> ERR.
  - Otherwise -> WAIT (WAIT_CYCLES>0) or straight to ack issue.
- WAIT: decrement each cycle; cyc low aborts to IDLE; at zero go to ack issue.
- Ack issue: ack_q registered; wb_ack_o = ack_q & wb_stb_i & wb_cyc_i. A beat transfers only when wb_ack_o=1.
- Classic (cti 000 or 111 at start): one ack, then CLASSIC_GAP (ack low one cycle), then IDLE.
- BURST (cti 010): ack_q held high while cyc; each transferred beat increments cur_adr by 1 word, modulo 2^AW (wraps 2^AW-1 -> 0). wb_adr_i ignored after the first beat.
  - stb low mid-burst: no transfer, cur_adr held, resume when stb returns.
  - Beat transferred with cti=111: burst_cnt_o++, ack_q cleared, go to CLASSIC_GAP.
  - cyc low mid-burst: abort to IDLE next cycle, burst_cnt_o unchanged; beats already transferred stay counted.
- Write on transferred beat with we=1: mem[cur_adr] byte lanes per wb_sel_i; sel=0000 acks but writes nothing.
- Read: wb_dat_o registered, = mem[address of the beat being acked]; read-after-write to same word in a later beat returns new data.
- ERR: wb_err_o high for one cycle (gated by stb&cyc like ack), no write, no counter change, then CLASSIC_GAP.
- Memory contents are not reset.

## Timing
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, beat_cnt_o=0, burst_cnt_o=0, state IDLE; reset mid-burst drops ack immediately (async).
- Classic latency: stb sampled high at edge n -> ack during cycle n+1+WAIT_CYCLES; max throughput one transfer per 3 cycles (request, ack, gap) at WAIT_CYCLES=0.
- Burst: first ack at n+1+WAIT_CYCLES, then one beat per cycle with stb high; N-beat burst completes in N+WAIT_CYCLES+1 cycles.
- Error: wb_err_o at n+1, independent of WAIT_CYCLES.
- wb_ack_o and wb_err_o are never high together; neither is high without stb&cyc.

## Test plan
- Reset, then classic write 0xDEADBEEF sel 1111 to 0x10, classic read 0x10, WAIT_CYCLES=0 -> ack at n+1, read 0xDEADBEEF, beat_cnt_o=2, burst_cnt_o=0.
- Fill words 0..7 with 0x01020304+0x04040404*i; 8-beat burst read from 0x0 (cti 010 x7, 111 last), WAIT_CYCLES=2 -> first ack at n+3, 8 consecutive acks, data matches pattern, burst_cnt_o=1, ack low after last beat.
- Burst read with stb dropped 2 cycles after beat 3 -> no ack in gap, beat 4 returns word 4, total 8 beats.
- AW=8, 4-beat burst from byte 0x3F8 -> words 254,255,0,1 returned in order.
- Byte write sel 0100 data 0x00AB0000 onto 0x11223344 -> reads 0x11AB3344; sel 0000 write -> ack, word unchanged.
- cti=010 with bte=01 -> wb_err_o one cycle at n+1, no ack, counters unchanged; cyc dropped mid-burst after 3 beats -> beat_cnt_o +3, burst_cnt_o unchanged, next classic read served normally.
